logic_unit_arbiter: RTL and testbench

Shares one combinational `logic_unit` (32-bit packed operand input, 2-bit operation select, 32-bit result) between two requesters. Each requester submits an operand pair and a select over a valid/ready handshake. The block arbitrates round-robin, drives the shared unit from internal registers, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between the ALU front-end ports and the single `logic_unit` instance.

---
 rtl/logic_unit_arbiter.sv | 112 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational logic_unit between two requesters.
// Each operation runs grant -> execute -> respond; operations never overlap.
module logic_unit_arbiter #(
  parameter int unsigned OP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op1,
  input  logic [OP_W-1:0]   req0_op2,
  input  logic [1:0]        req0_sel,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op1,
  input  logic [OP_W-1:0]   req1_op2,
  input  logic [1:0]        req1_sel,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [2*OP_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic [2*OP_W-1:0] logic_in,
  output logic [1:0]        logic_lines,
  input  logic [2*OP_W-1:0] logic_out,
  output logic              busy,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_q;
  logic [OP_W-1:0]   op1_q, op2_q;
  logic [1:0]        sel_q;
  logic              id_q;
  logic [2*OP_W-1:0] resp_data_q;
  logic              resp_id_q;
  logic              resp_valid_q;
  logic              busy_q;
  logic [15:0]       ops_done_q, ops_done_d;
  logic              gnt_valid;
  logic              gnt_id;

  always_comb begin
    state_d    = state_q;
    ops_done_d = ops_done_q;
    gnt_valid  = 1'b0;
    gnt_id     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          gnt_valid = 1'b1;
          // Under contention the requester not granted last time wins.
          gnt_id    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          state_d   = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          state_d    = StIdle;
          ops_done_d = ops_done_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req0_ready = gnt_valid & ~gnt_id & ~rst;
  assign req1_ready = gnt_valid &  gnt_id & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      sel_q        <= '0;
      id_q         <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      ops_done_q   <= ops_done_d;
      busy_q       <= (state_d != StIdle);
      resp_valid_q <= (state_d == StResp);
      if (gnt_valid) begin
        op1_q  <= gnt_id ? req1_op1 : req0_op1;
        op2_q  <= gnt_id ? req1_op2 : req0_op2;
        sel_q  <= gnt_id ? req1_sel : req0_sel;
        id_q   <= gnt_id;
        last_q <= gnt_id;
      end
      if (state_q == StExec) begin
        resp_data_q <= logic_out;
        resp_id_q   <= id_q;
      end
    end
  end

  assign logic_in    = {op1_q, op2_q};
  assign logic_lines = sel_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign busy        = busy_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [1:0]  req0_sel = '0, req1_sel = '0;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_ready = 1'b1;
  logic [31:0] resp_data, logic_in, logic_out;
  logic [1:0]  logic_lines;
  logic        busy;
  logic [15:0] ops_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stub logic_unit.
  assign logic_out = logic_in ^ {30'b0, logic_lines};

  logic_unit_arbiter #(.OP_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_sel(req1_sel), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .logic_in(logic_in), .logic_lines(logic_lines),
    .logic_out(logic_out), .busy(busy), .ops_done(ops_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_age: cycles since grant (0 = free, 1 = computing, 2 = result offered).
  int          m_age = 0;
  logic        m_last = 1'b1, m_owner = 1'b0, m_rid = 1'b0;
  logic [31:0] m_in = '0, m_rdata = '0;
  logic [1:0]  m_lines = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] cnt_ofs = '0;

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_age <= 0; m_last <= 1'b1; m_owner <= 1'b0; m_rid <= 1'b0;
      m_in <= '0; m_rdata <= '0; m_lines <= '0; m_cnt <= '0;
    end else if (m_age == 0) begin
      if (req0_valid || req1_valid) begin
        m_age   <= 1;
        m_last  <= pick(req0_valid, req1_valid, m_last);
        m_owner <= pick(req0_valid, req1_valid, m_last);
        if (pick(req0_valid, req1_valid, m_last)) begin
          m_in <= {req1_op1, req1_op2}; m_lines <= req1_sel;
        end else begin
          m_in <= {req0_op1, req0_op2}; m_lines <= req0_sel;
        end
      end
    end else if (m_age == 1) begin
      m_rdata <= m_in ^ {30'b0, m_lines};
      m_rid   <= m_owner;
      m_age   <= 2;
    end else if (resp_ready) begin
      m_cnt <= m_cnt + 16'd1;
      m_age <= 0;
    end
  end

  always @(negedge clk) begin
    logic any_v, g;
    any_v = req0_valid || req1_valid;
    g     = pick(req0_valid, req1_valid, m_last);
    check("req0_ready", {31'b0, req0_ready}, {31'b0, !rst && m_age == 0 && any_v && !g});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, !rst && m_age == 0 && any_v && g});
    check("busy", {31'b0, busy}, {31'b0, m_age != 0});
    check("resp_valid", {31'b0, resp_valid}, {31'b0, m_age == 2});
    check("resp_data", resp_data, m_rdata);
    check("resp_id", {31'b0, resp_id}, {31'b0, m_rid});
    check("logic_in", logic_in, m_in);
    check("logic_lines", {30'b0, logic_lines}, {30'b0, m_lines});
    check("ops_done", {16'b0, ops_done}, {16'b0, m_cnt + cnt_ofs});
  end

  // Grant and response logs for the ordering scenario.
  bit          gq[$];
  logic [31:0] rdq[$];
  bit          riq[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) gq.push_back(1'b0);
      if (req1_valid && req1_ready) gq.push_back(1'b1);
      if (resp_valid && resp_ready) begin
        rdq.push_back(resp_data);
        riq.push_back(resp_id);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input bit id);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL handshake%0d: got no ready expected ready within 20 cycles", id);
    end else begin
      step();
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset held with a pending request.
    req0_valid = 1'b1; req0_op1 = 16'hA5A5; req0_op2 = 16'h0F0F; req0_sel = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_ops_done", {16'b0, ops_done}, 32'd0);
      check("rst_logic_in", logic_in, 32'd0);
    end
    step();
    rst = 1'b0;

    // 2: single request.
    handshake(1'b0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("t2_logic_in", logic_in, 32'hA5A50F0F);
    check("t2_ready_pulse", {31'b0, req0_ready}, 32'd0);
    step();
    @(negedge clk);
    check("t2_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("t2_resp_data", resp_data, 32'hA5A50F0D);
    check("t2_resp_id", {31'b0, resp_id}, 32'd0);
    step();
    @(negedge clk);
    check("t2_ops_done", {16'b0, ops_done}, 32'd1);
    step();

    // 3: contention from a fresh pointer.
    do_reset();
    gq.delete(); rdq.delete(); riq.delete();
    req0_op1 = 16'h1111; req0_op2 = 16'h2222; req0_sel = 2'd1;
    req1_op1 = 16'h3333; req1_op2 = 16'h4444; req1_sel = 2'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && gq.size() < 4; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();
    check("t3_grants", gq.size(), 32'd4);
    check("t3_resps", rdq.size(), 32'd4);
    if (gq.size() >= 4 && rdq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_grant_order", {31'b0, gq[i]}, i % 2);
        check("t3_resp_id", {31'b0, riq[i]}, i % 2);
        check("t3_resp_data", rdq[i], (i % 2) ? 32'h33334447 : 32'h11112223);
      end
    end

    // 4: response backpressure with req1 pending (pointer last = 1, so req0 wins).
    resp_ready = 1'b0;
    req0_op1 = 16'hDEAD; req0_op2 = 16'hBEEF; req0_sel = 2'd0;
    req1_op1 = 16'h5555; req1_op2 = 16'hAAAA; req1_sel = 2'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    handshake(1'b0);
    req0_valid = 1'b0;
    step();
    repeat (5) begin
      @(negedge clk);
      check("t4_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("t4_resp_data", resp_data, 32'hDEADBEEF);
      check("t4_resp_id", {31'b0, resp_id}, 32'd0);
      check("t4_req1_ready", {31'b0, req1_ready}, 32'd0);
      check("t4_busy", {31'b0, busy}, 32'd1);
      step();
    end
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    check("t4_req1_grant", {31'b0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("t4_req1_data", resp_data, 32'h5555AAA8);
    check("t4_req1_id", {31'b0, resp_id}, 32'd1);
    step();

    // 5: reset while computing discards the operation.
    do_reset();
    req0_op1 = 16'h0001; req0_op2 = 16'h0002; req0_sel = 2'd1;
    req0_valid = 1'b1;
    handshake(1'b0);
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_resp", {31'b0, resp_valid}, 32'd0);
      check("t5_ops_done", {16'b0, ops_done}, 32'd0);
      step();
    end
    req0_valid = 1'b1;
    handshake(1'b0);
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_resp_data", resp_data, 32'h00010003);
    step();
    @(negedge clk);
    check("t5_ops_after", {16'b0, ops_done}, 32'd1);

    // 6: counter wrap from a preloaded 0xFFFF.
    #1;
    force dut.ops_done_q = 16'hFFFF;
    cnt_ofs = 16'hFFFF - m_cnt;
    step();
    release dut.ops_done_q;
    @(negedge clk);
    check("t6_preload", {16'b0, ops_done}, 32'h0000FFFF);
    step();
    req0_valid = 1'b1;
    handshake(1'b0);
    req0_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("t6_wrap", {16'b0, ops_done}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
